// File: rtl/spi_host_mc_pkg.sv
// spi_pkg: shared config/state types and port defaults for the multi-card SPI host.
package spi_pkg;
   typedef struct packed {
      logic       autoread;
      logic       wait_en;
      logic       cpha;
      logic       cpol;
      logic [3:0] div;
   } spi_cfg_t;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} spi_state_t;

   localparam int         ST_BUSY       = 0;
   localparam int         ST_OVR        = 1;
   localparam logic [7:0] PORT_DATA_DEF = 8'hEB;
   localparam logic [7:0] PORT_CS_DEF   = 8'hE7;
   localparam logic [7:0] PORT_CFG_DEF  = 8'hE9;
endpackage

// File: rtl/spi_host_mc_if.sv
// cpu_bus: low address byte, write data and I/O strobes as seen by port-mapped peripherals.
interface cpu_bus;
   logic [7:0] a;
   logic [7:0] d;
   logic       ioreq;
   logic       rd;
   logic       wr;
   modport master (output a, d, ioreq, rd, wr);
   modport slave  (input  a, d, ioreq, rd, wr);
endinterface

// File: rtl/spi_host_mc_shift_engine.sv
// spi_shift_engine: SCK divider, half-period sequencing and shift register for one SPI byte.
module spi_shift_engine import spi_pkg::*; (
   input  logic       clk28,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic [7:0] tx_i,
   input  logic [3:0] div_i,
   input  logic       cpol_i,
   input  logic       cpha_i,
   input  logic       miso_i,
   output logic       busy_o,
   output logic       done_o,
   output logic [7:0] rx_o,
   output logic       sck_o,
   output logic       mosi_o
);
   spi_state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d, hc_q, hc_d;
   logic [7:0] sr_q, sr_d;
   logic       smp_q, smp_d, out_q, out_d;
   logic       tick, lead;

   assign tick = cnt_q == 4'd0;
   assign lead = !hc_q[0];

   always_ff @(posedge clk28 or negedge rst_n)
      if (!rst_n) state_q <= S_IDLE;
      else state_q <= state_d;

   always_comb
      state_d = (state_q == S_IDLE && start_i)                    ? S_SHIFT :
                (state_q == S_SHIFT && tick && hc_q == 4'd15)     ? S_DONE  :
                (state_q == S_DONE)                               ? S_IDLE  : state_q;

   always_comb begin
      busy_o = state_q != S_IDLE;
      done_o = state_q == S_DONE;
      sck_o  = (state_q == S_SHIFT) ? cpol_i ^ hc_q[0] : cpol_i;
      mosi_o = (state_q == S_SHIFT) ? out_q : 1'b1;
      rx_o   = sr_q;
   end

   // Even half-periods end in a leading SCK edge, odd ones in a trailing edge.
   always_comb begin
      cnt_d = cnt_q;
      hc_d  = hc_q;
      sr_d  = sr_q;
      smp_d = smp_q;
      out_d = out_q;
      if (state_q == S_IDLE && start_i) begin
         cnt_d = div_i;
         hc_d  = 4'd0;
         sr_d  = tx_i;
         out_d = cpha_i | tx_i[7];
      end else if (state_q == S_SHIFT && !tick) begin
         cnt_d = cnt_q - 4'd1;
      end else if (state_q == S_SHIFT) begin
         cnt_d = div_i;
         hc_d  = hc_q + 4'd1;
         if (!cpha_i && lead) smp_d = miso_i;
         else if (!cpha_i) begin
            sr_d  = {sr_q[6:0], smp_q};
            out_d = sr_q[6];
         end else if (lead) begin
            out_d = sr_q[7];
            sr_d  = {sr_q[6:0], 1'b0};
         end else sr_d[0] = miso_i;
      end
   end

   always_ff @(posedge clk28 or negedge rst_n)
      if (!rst_n) begin
         cnt_q <= 4'd0;
         hc_q  <= 4'd0;
         sr_q  <= 8'hFF;
         smp_q <= 1'b1;
         out_q <= 1'b1;
      end else begin
         cnt_q <= cnt_d;
         hc_q  <= hc_d;
         sr_q  <= sr_d;
         smp_q <= smp_d;
         out_q <= out_d;
      end
endmodule

// File: rtl/spi_host_mc.sv
// spi_host_mc: CPU port-mapped SPI host with chip selects, config, status and optional CPU wait.
module spi_host_mc import spi_pkg::*; #(
   parameter int         NCS       = 2,
   parameter logic [7:0] PORT_DATA = PORT_DATA_DEF,
   parameter logic [7:0] PORT_CS   = PORT_CS_DEF,
   parameter logic [7:0] PORT_CFG  = PORT_CFG_DEF,
   parameter logic [3:0] DIV_RST   = 4'd0
) (
   input  logic           clk28,
   input  logic           rst_n,
   input  logic           en_i,
   cpu_bus.slave          bus,
   output logic [7:0]     d_out_o,
   output logic           d_out_active_o,
   output logic           cpuwait_o,
   output logic           busy_o,
   input  logic           spi_miso_i,
   output logic           spi_mosi_o,
   output logic           spi_sck_o,
   output logic [NCS-1:0] spi_cs_n_o
);
   localparam spi_cfg_t CFG_RST = spi_cfg_t'({4'b0000, DIV_RST});

   logic [2:0]     hit, rise, hit_q, hit_d;
   spi_cfg_t       cfg_q, cfg_d, pend_q, pend_d;
   logic           pend_v_q, pend_v_d, ovr_q, ovr_d, act_q, act_d;
   logic           dwait_q, dwait_d, start_q, start_d;
   logic [NCS-1:0] cs_q, cs_d;
   logic [7:0]     rdata_q, rdata_d, tx_q, tx_d, rx, st;
   logic           acc, busy, eng_busy, eng_done, data_evt, hold, data_act;

   assign acc      = en_i && bus.ioreq && (bus.rd || bus.wr);
   assign hit      = {acc && bus.a == PORT_CFG, acc && bus.a == PORT_CS, acc && bus.a == PORT_DATA};
   assign rise     = hit & ~hit_q;
   assign busy     = start_q | eng_busy;
   // A data access that met a busy engine with wait enabled is held and retried once idle.
   assign data_evt = rise[0] | (dwait_q & hit[0]);
   assign hold     = data_evt && busy && cfg_q.wait_en;
   assign data_act = data_evt && !hold;

   always_comb begin
      st          = 8'h00;
      st[ST_BUSY] = busy;
      st[ST_OVR]  = ovr_q;
   end

   always_comb begin
      hit_d    = hit;
      cfg_d    = cfg_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      cs_d     = cs_q;
      ovr_d    = ovr_q;
      rdata_d  = rdata_q;
      tx_d     = tx_q;
      start_d  = 1'b0;
      dwait_d  = hold;
      act_d    = |hit && bus.rd;
      if (pend_v_q && (eng_done || !busy)) begin
         cfg_d    = pend_q;
         pend_v_d = 1'b0;
      end
      if (data_act) begin
         if (bus.rd) rdata_d = rx;
         if (busy) ovr_d = 1'b1;
         else if (bus.wr || cfg_q.autoread) begin
            start_d = 1'b1;
            tx_d    = bus.wr ? bus.d : 8'hFF;
         end
      end
      if (rise[1] && bus.wr) cs_d = bus.d[NCS-1:0];
      else if (rise[1]) begin
         rdata_d = st;
         ovr_d   = 1'b0;
      end
      if (rise[2] && bus.wr && busy) begin
         pend_d   = spi_cfg_t'(bus.d);
         pend_v_d = 1'b1;
      end else if (rise[2] && bus.wr) cfg_d = spi_cfg_t'(bus.d);
      else if (rise[2]) rdata_d = cfg_q;
   end

   always_ff @(posedge clk28 or negedge rst_n)
      if (!rst_n) begin
         hit_q    <= 3'b000;
         cfg_q    <= CFG_RST;
         pend_q   <= CFG_RST;
         pend_v_q <= 1'b0;
         cs_q     <= '1;
         ovr_q    <= 1'b0;
         rdata_q  <= 8'hFF;
         tx_q     <= 8'hFF;
         start_q  <= 1'b0;
         dwait_q  <= 1'b0;
         act_q    <= 1'b0;
      end else begin
         hit_q    <= hit_d;
         cfg_q    <= cfg_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         cs_q     <= cs_d;
         ovr_q    <= ovr_d;
         rdata_q  <= rdata_d;
         tx_q     <= tx_d;
         start_q  <= start_d;
         dwait_q  <= dwait_d;
         act_q    <= act_d;
      end

   spi_shift_engine u_eng (
      .clk28   (clk28),
      .rst_n   (rst_n),
      .start_i (start_q),
      .tx_i    (tx_q),
      .div_i   (cfg_q.div),
      .cpol_i  (cfg_q.cpol),
      .cpha_i  (cfg_q.cpha),
      .miso_i  (spi_miso_i),
      .busy_o  (eng_busy),
      .done_o  (eng_done),
      .rx_o    (rx),
      .sck_o   (spi_sck_o),
      .mosi_o  (spi_mosi_o)
   );

   assign d_out_o        = rdata_q;
   assign d_out_active_o = act_q;
   assign cpuwait_o      = hold;
   assign busy_o         = busy;
   assign spi_cs_n_o     = cs_q;
endmodule
